// File: rtl/downsample.sv
// Boxcar decimator: averages each block of DOWN_FACTOR accepted samples and holds the result
// under a valid/ready handshake. Define DOWNSAMPLE_ROUND_EN for round-half-up instead of floor.
module downsample #(
    parameter int DOWN_FACTOR = 8,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic                     valid_in,
    input  logic                     sync_in,
    input  logic                     ready_in,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     valid_out,
    output logic                     overrun
);

    localparam int SH    = $clog2(DOWN_FACTOR);
    localparam int ACC_W = DATA_W + SH;

    logic signed [ACC_W-1:0]  acc_reg;
    logic        [SH-1:0]     phase_reg;

    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  biased_next;
    logic signed [ACC_W-1:0]  shifted_next;
    logic signed [DATA_W-1:0] result_next;
    logic                     last_phase;
    logic                     complete;

    assign sample_ext = {{SH{audio_in[DATA_W-1]}}, audio_in};
    assign sum_next   = acc_reg + sample_ext;

`ifdef DOWNSAMPLE_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(DOWN_FACTOR / 2);
    // Adding N/2 before the floor shift cannot overflow: N*max + N/2 < N*2^(DATA_W-1).
    assign biased_next = sum_next + HALF;
`else
    assign biased_next = sum_next;
`endif

    assign shifted_next = biased_next >>> SH;
    assign result_next  = shifted_next[DATA_W-1:0];
    assign last_phase   = (phase_reg == SH'(DOWN_FACTOR - 1));
    // Realign wins over completion, so a sync cycle never emits a result.
    assign complete     = valid_in && !sync_in && last_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            phase_reg <= '0;
            audio_out <= '0;
            valid_out <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (sync_in) begin
                acc_reg   <= valid_in ? sample_ext : '0;
                phase_reg <= valid_in ? SH'(1) : '0;
            end else if (valid_in) begin
                if (last_phase) begin
                    acc_reg   <= '0;
                    phase_reg <= '0;
                end else begin
                    acc_reg   <= sum_next;
                    phase_reg <= phase_reg + SH'(1);
                end
            end

            if (complete) begin
                audio_out <= result_next;
                valid_out <= 1'b1;
                overrun   <= valid_out && !ready_in;
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_downsample.sv
// Scoreboard bench for downsample: a list-of-samples averaging model feeds an expected queue,
// a negedge monitor pops and compares on every output transfer.
module tb_downsample;

    localparam int DF = 8;
    localparam int W  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] audio_in = '0;
    logic                valid_in = 1'b0;
    logic                sync_in = 1'b0;
    logic                ready_in = 1'b0;
    logic signed [W-1:0] audio_out;
    logic                valid_out;
    logic                overrun;

    downsample #(.DOWN_FACTOR(DF), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .valid_in(valid_in),
        .sync_in(sync_in), .ready_in(ready_in), .audio_out(audio_out),
        .valid_out(valid_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_q[$];
    int blk[$];
    bit exp_valid = 1'b0;
    bit exp_ovr   = 1'b0;
    bit mon_en    = 1'b0;
    int last_out  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Average of the collected block: floor(sum/N), or floor((sum+N/2)/N) when rounding.
    function automatic int block_avg();
        int sum = 0;
        int q;
        foreach (blk[i]) sum += blk[i];
`ifdef DOWNSAMPLE_ROUND_EN
        sum += DF / 2;
`endif
        q = sum / DF;
        if ((sum % DF) != 0 && sum < 0) q -= 1;
        return q;
    endfunction

    task automatic step(input bit v, input bit s, input int d, input bit r);
        bit new_r = 1'b0;
        bit n_ovr = 1'b0;
        bit n_held;
        int res = 0;
        valid_in = v;
        sync_in  = s;
        audio_in = d[W-1:0];
        ready_in = r;
        if (s) begin
            blk.delete();
            if (v) blk.push_back(d);
        end else if (v) begin
            blk.push_back(d);
            if (blk.size() == DF) begin
                new_r = 1'b1;
                res = block_avg();
                blk.delete();
            end
        end
        if (new_r) begin
            if (exp_valid && !r) begin
                exp_q[exp_q.size()-1] = res;
                n_ovr = 1'b1;
            end else begin
                exp_q.push_back(res);
            end
            n_held = 1'b1;
        end else begin
            n_held = exp_valid && !r;
        end
        @(posedge clk);
        exp_valid = n_held;
        exp_ovr   = n_ovr;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        sync_in = 1'b0;
        @(posedge clk);
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        exp_q.delete();
        blk.delete();
        #1;
        rst_n = 1'b1;
        check("reset_audio_out", int'(audio_out), 0);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_overrun", int'(overrun), 0);
    endtask

    task automatic feed(input int n, input int d, input bit r);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, d, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, r);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_out", int'(valid_out), int'(exp_valid));
            check("overrun", int'(overrun), int'(exp_ovr));
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("audio_out", int'(audio_out), exp_q.pop_front());
                    last_out = int'(audio_out);
                end
            end
        end
    end

    initial begin
        logic signed [W-1:0] rnd;
        int gaps;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        feed(DF, 100, 1'b1);
        idle(2, 1'b1);
        check("const_100", last_out, 100);

        for (int i = 0; i < DF; i++) step(1'b1, 1'b0, i, 1'b1);
        idle(2, 1'b1);
`ifdef DOWNSAMPLE_ROUND_EN
        check("ramp", last_out, 4);
`else
        check("ramp", last_out, 3);
`endif

        feed(DF, -1, 1'b1);
        idle(2, 1'b1);
        check("all_minus1", last_out, -1);

        feed(DF - 1, 0, 1'b1);
        feed(1, -1, 1'b1);
        idle(2, 1'b1);
`ifdef DOWNSAMPLE_ROUND_EN
        check("zeros_then_minus1", last_out, 0);
`else
        check("zeros_then_minus1", last_out, -1);
`endif

        feed(DF, -32768, 1'b1);
        idle(2, 1'b1);
        check("min_value", last_out, -32768);

        // Backpressure: second result overwrites the first.
        feed(DF, 10, 1'b0);
        feed(DF, 20, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        check("overwrite_value", last_out, 20);

        // Completion coincides with a transfer of the held result.
        feed(DF, 30, 1'b0);
        feed(DF - 1, 40, 1'b0);
        feed(1, 40, 1'b1);
        idle(2, 1'b1);
        check("transfer_and_load", last_out, 40);

        // Realign discards the partial block; gaps do not disturb accumulation.
        feed(5, 1000, 1'b1);
        step(1'b0, 1'b1, 0, 1'b1);
        for (int i = 0; i < DF; i++) begin
            gaps = $urandom_range(0, 3);
            idle(gaps, 1'b1);
            step(1'b1, 1'b0, 8, 1'b1);
        end
        idle(2, 1'b1);
        check("realign_gaps", last_out, 8);

        step(1'b1, 1'b1, 16, 1'b1);
        feed(DF - 1, 0, 1'b1);
        idle(2, 1'b1);
        check("sync_with_sample", last_out, 2);

        // Reset with a held result and a partial block.
        feed(DF, 10, 1'b0);
        feed(4, 7, 1'b0);
        do_reset();
        feed(DF, 50, 1'b1);
        idle(2, 1'b1);
        check("after_reset", last_out, 50);

        for (int i = 0; i < 3000; i++) begin
            rnd = W'($urandom);
            step(($urandom % 4) != 0, ($urandom % 40) == 0, int'(rnd), ($urandom % 3) != 0);
        end
        idle(4, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
